adexp_neuron_array: RTL and testbench

ADEXP_NEURON_ARRAY -- requirements
Module: adexp_neuron_array

---
 rtl/adexp_pkg.sv | 25 ++
 rtl/adexp_update.sv | 77 +++++++
 rtl/adexp_neuron_array.sv | 155 +++++++++++++++
 tb/tb_adexp_neuron_array.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adexp_pkg.sv
// Shared constants and types for the time-multiplexed AdEx neuron array.
// Voltages and currents are Q(W-8).8 fixed point; the integer values below are the Q8.8 encodings.
package adexp_pkg;

  localparam int V_REST  = -17920;
  localparam int V_T     = -12800;
  localparam int V_PEAK  = 5120;
  localparam int V_RESET = -14848;
  localparam int B       = 512;

  localparam int LEAK_SHIFT      = 4;
  localparam int EXP_SHIFT       = 8;
  localparam int EXP_SCALE_SHIFT = 2;
  localparam int CUR_SHIFT       = 2;
  localparam int ADAPT_SHIFT     = 3;
  localparam int W_TAU_SHIFT     = 6;

  localparam int REF_W = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/adexp_update.sv
// One Euler step of a single AdEx channel, including the spike/reset/refractory decision.
// Purely combinational; the array steps channels through this block one at a time.
module adexp_update
  import adexp_pkg::*;
#(
  parameter int W      = 16,
  parameter int REFRAC = 2
) (
  input  logic signed [W-1:0]     v,
  input  logic signed [W-1:0]     w,
  input  logic signed [W-1:0]     i_cur,
  input  logic        [REF_W-1:0] ref_cnt,
  output logic signed [W-1:0]     v_new,
  output logic signed [W-1:0]     w_new,
  output logic        [REF_W-1:0] ref_new,
  output logic                    spike
);

  // Wide enough for (v - V_T)^2 plus the summed terms without any overflow.
  localparam int WX = 2 * W + 4;

  localparam logic signed [WX-1:0] MAX_X = {{(WX-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WX-1:0] MIN_X = {{(WX-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [WX-1:0] VR_X  = WX'(V_REST);
  localparam logic signed [WX-1:0] VT_X  = WX'(V_T);
  localparam logic signed [WX-1:0] VP_X  = WX'(V_PEAK);
  localparam logic signed [WX-1:0] B_X   = WX'(B);
  localparam logic signed [W-1:0]  V_RESET_W = W'(V_RESET);

  function automatic logic signed [WX-1:0] ext(input logic signed [W-1:0] x);
    return {{(WX-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [WX-1:0] x);
    if (x > MAX_X) return MAX_X[W-1:0];
    if (x < MIN_X) return MIN_X[W-1:0];
    return x[W-1:0];
  endfunction

  logic signed [WX-1:0] v_x, w_x, i_x, leak, d, dsq, ex, a;
  logic signed [W-1:0]  v_n, w_n, w_b;

  always_comb begin
    v_x = ext(v);
    w_x = ext(w);
    i_x = ext(i_cur);

    leak = (VR_X - v_x) >>> LEAK_SHIFT;
    d    = v_x - VT_X;
    dsq  = d * d;
    ex   = '0;
    if (d > 0) ex = (dsq >>> EXP_SHIFT) >>> EXP_SCALE_SHIFT;
    if (ex > MAX_X) ex = MAX_X;

    v_n = sat(v_x + leak + ex + ((i_x - w_x) >>> CUR_SHIFT));
    a   = (v_x - VR_X) >>> ADAPT_SHIFT;
    w_n = sat(w_x + ((a - w_x) >>> W_TAU_SHIFT));
    w_b = sat(ext(w_n) + B_X);

    v_new   = v_n;
    w_new   = w_n;
    ref_new = '0;
    spike   = 1'b0;

    // Refractory channels are pinned at reset potential and cannot fire.
    if (ref_cnt != '0) begin
      v_new   = V_RESET_W;
      ref_new = ref_cnt - REF_W'(1);
    end else if (ext(v_n) >= VP_X) begin
      v_new   = V_RESET_W;
      w_new   = w_b;
      ref_new = REF_W'(REFRAC);
      spike   = 1'b1;
    end
  end

endmodule

// File: rtl/adexp_neuron_array.sv
// N_CH AdEx neurons sharing one update datapath: each tick starts a sweep that
// updates one channel per cycle and reports the spike vector with a done pulse.
module adexp_neuron_array
  import adexp_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int W      = 16,
  parameter int REFRAC = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        tick,
  input  logic [N_CH*W-1:0]                           i_in,
  output logic                                        busy,
  output logic                                        done,
  output logic [N_CH-1:0]                             spike,
  output logic                                        overrun,
  input  logic                                        clr_overrun,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_ch,
  output logic [W-1:0]                                rd_v,
  output logic [W-1:0]                                rd_w
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [N_CH*W-1:0]     i_snap_q, i_snap_d;
  logic signed [W-1:0]   v_q [N_CH];
  logic signed [W-1:0]   v_d [N_CH];
  logic signed [W-1:0]   w_q [N_CH];
  logic signed [W-1:0]   w_d [N_CH];
  logic [REF_W-1:0]      ref_q [N_CH];
  logic [REF_W-1:0]      ref_d [N_CH];
  logic [N_CH-1:0]       spike_acc_q, spike_acc_d, spike_q, spike_d;
  logic                  busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [W-1:0]          rd_v_q, rd_v_d, rd_w_q, rd_w_d;
  logic                  tick_ignored;

  logic signed [W-1:0]   upd_v, upd_w;
  logic [REF_W-1:0]      upd_ref;
  logic                  upd_spike;

  adexp_update #(
    .W      (W),
    .REFRAC (REFRAC)
  ) u_update (
    .v       (v_q[ch_q]),
    .w       (w_q[ch_q]),
    .i_cur   (i_snap_q[ch_q*W +: W]),
    .ref_cnt (ref_q[ch_q]),
    .v_new   (upd_v),
    .w_new   (upd_w),
    .ref_new (upd_ref),
    .spike   (upd_spike)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    i_snap_d    = i_snap_q;
    v_d         = v_q;
    w_d         = w_q;
    ref_d       = ref_q;
    spike_acc_d = spike_acc_q;
    spike_d     = spike_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;

    // A tick landing on the done cycle is dropped too, so sweeps never overlap.
    tick_ignored = tick && ((state_q == RUN) || done_q);

    case (state_q)
      IDLE: begin
        if (tick && !done_q) begin
          state_d     = RUN;
          ch_d        = '0;
          i_snap_d    = i_in;
          spike_acc_d = '0;
        end
      end
      RUN: begin
        v_d[ch_q]         = upd_v;
        w_d[ch_q]         = upd_w;
        ref_d[ch_q]       = upd_ref;
        spike_acc_d[ch_q] = upd_spike;
        if (ch_q == LAST_CH) begin
          state_d = IDLE;
          done_d  = 1'b1;
          spike_d = spike_acc_d;
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);

    if (tick_ignored)     overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;

    rd_v_d = '0;
    rd_w_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_ch == CW'(k)) begin
        rd_v_d = v_q[k];
        rd_w_d = w_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      i_snap_q    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        v_q[k]   <= W'(V_REST);
        w_q[k]   <= '0;
        ref_q[k] <= '0;
      end
      spike_acc_q <= '0;
      spike_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rd_v_q      <= '0;
      rd_w_q      <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      i_snap_q    <= i_snap_d;
      v_q         <= v_d;
      w_q         <= w_d;
      ref_q       <= ref_d;
      spike_acc_q <= spike_acc_d;
      spike_q     <= spike_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      rd_v_q      <= rd_v_d;
      rd_w_q      <= rd_w_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign spike   = spike_q;
  assign overrun = overrun_q;
  assign rd_v    = rd_v_q;
  assign rd_w    = rd_w_q;

endmodule

// File: tb/tb_adexp_neuron_array.sv
// Randomised and directed bench for adexp_neuron_array against a per-sweep
// arithmetic model of the neuron equations held in plain integer arrays.
module tb_adexp_neuron_array;

  localparam int N_CH   = 4;
  localparam int W      = 16;
  localparam int REFRAC = 2;

  localparam longint VREST  = -17920;
  localparam longint VT     = -12800;
  localparam longint VPEAK  = 5120;
  localparam longint VRESET = -14848;
  localparam longint BJUMP  = 512;
  localparam longint VMAX   = 32767;
  localparam longint VMIN   = -32768;

  logic              clk = 1'b0;
  logic              rst, tick, clr_overrun;
  logic [N_CH*W-1:0] i_in;
  logic [1:0]        rd_ch;
  logic              busy, done, overrun;
  logic [N_CH-1:0]   spike;
  logic [W-1:0]      rd_v, rd_w;

  always #5 clk = ~clk;

  adexp_neuron_array #(
    .N_CH   (N_CH),
    .W      (W),
    .REFRAC (REFRAC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .i_in        (i_in),
    .busy        (busy),
    .done        (done),
    .spike       (spike),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .rd_ch       (rd_ch),
    .rd_v        (rd_v),
    .rd_w        (rd_w)
  );

  int errors = 0;
  int checks = 0;

  longint          mv [N_CH];
  longint          mw [N_CH];
  int              mref [N_CH];
  logic [N_CH-1:0] mspike;
  longint          last_v [N_CH];
  longint          last_w [N_CH];

  function automatic longint satw(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < N_CH; k++) begin
      mv[k]   = VREST;
      mw[k]   = 0;
      mref[k] = 0;
    end
    mspike = '0;
  endtask

  // Advance every modelled neuron by one Euler step with the given currents.
  task automatic modelSweep(input logic [N_CH*W-1:0] cur);
    longint v, w, i, leak, d, ex, vn, a, wn;
    logic [N_CH-1:0] sp;
    sp = '0;
    for (int k = 0; k < N_CH; k++) begin
      v    = mv[k];
      w    = mw[k];
      i    = longint'($signed(cur[k*W +: W]));
      leak = (VREST - v) >>> 4;
      d    = v - VT;
      ex   = (d > 0) ? (((d * d) >>> 8) >>> 2) : 0;
      if (ex > VMAX) ex = VMAX;
      vn   = satw(v + leak + ex + ((i - w) >>> 2));
      a    = (v - VREST) >>> 3;
      wn   = satw(w + ((a - w) >>> 6));
      if (mref[k] > 0) begin
        mv[k] = VRESET;
        mw[k] = wn;
        mref[k]--;
      end else if (vn >= VPEAK) begin
        mv[k]   = VRESET;
        mw[k]   = satw(wn + BJUMP);
        mref[k] = REFRAC;
        sp[k]   = 1'b1;
      end else begin
        mv[k] = vn;
        mw[k] = wn;
      end
    end
    mspike = sp;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick = 1'b0;
    clr_overrun = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic readAll();
    for (int k = 0; k < N_CH; k++) begin
      rd_ch = 2'(k);
      @(posedge clk); #1;
      last_v[k] = longint'($signed(rd_v));
      last_w[k] = longint'($signed(rd_w));
      checkOutput($sformatf("rd_v[%0d]", k), last_v[k], mv[k]);
      checkOutput($sformatf("rd_w[%0d]", k), last_w[k], mw[k]);
    end
  endtask

  // Pulse tick for one cycle; returns in the first busy cycle.
  task automatic startTick(input logic [N_CH*W-1:0] cur);
    i_in = cur;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    modelSweep(cur);
  endtask

  task automatic waitDone(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [N_CH*W-1:0] cur);
    int cyc;
    startTick(cur);
    checkOutput("busy_run", busy, 1);
    waitDone(cyc);
    checkOutput("done_latency", cyc, N_CH + 1);
    checkOutput("spike_at_done", spike, mspike);
    readAll();
    checkOutput("spike_hold", spike, mspike);
    checkOutput("busy_idle", busy, 0);
  endtask

  function automatic logic [N_CH*W-1:0] randCur();
    logic [N_CH*W-1:0] c;
    for (int k = 0; k < N_CH; k++) begin
      if ($urandom_range(0, 1) == 1) c[k*W +: W] = W'($urandom_range(0, 14000));
      else                           c[k*W +: W] = W'($urandom);
    end
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_CH*W-1:0] cur, other;
    longint prev_v [N_CH];
    int nd, cyc;

    rst = 1'b1; tick = 1'b0; clr_overrun = 1'b0; i_in = '0; rd_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_spike", spike, 0);
    checkOutput("rst_rd_v", rd_v, 0);
    checkOutput("rst_rd_w", rd_w, 0);
    rst = 1'b0;
    modelReset();
    readAll();

    // Quiet input: everything stays at rest.
    applyStimulus('0);

    // Strong drive on channel 2: integrate, fire, refractory, resume.
    doReset();
    cur = '0;
    cur[2*W +: W] = 16'h7FFF;
    applyStimulus(cur);
    checkOutput("s1_spike", spike, 0);
    checkOutput("s1_ch2_v", last_v[2], -9729);
    applyStimulus(cur);
    checkOutput("s2_spike", spike, 4);
    checkOutput("s2_ch2_v", last_v[2], -14848);
    checkOutput("s2_ch2_w", last_w[2], 527);
    for (int s = 3; s <= 4; s++) begin
      applyStimulus(cur);
      checkOutput($sformatf("s%0d_spike2", s), spike[2], 0);
      checkOutput($sformatf("s%0d_ch2_v", s), last_v[2], -14848);
    end
    applyStimulus(cur);
    checkOutput("s5_resumed", last_v[2] != VRESET, 1);

    // Tick while busy is dropped, and later i_in changes do not leak into the sweep.
    doReset();
    cur = randCur();
    startTick(cur);
    other = ~cur;
    i_in = other;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    nd = 0;
    repeat (12) begin
      if (done === 1'b1) begin
        nd++;
        checkOutput("ovr_spike", spike, mspike);
      end
      @(posedge clk); #1;
    end
    checkOutput("ovr_done_count", nd, 1);
    checkOutput("ovr_flag_set", overrun, 1);
    readAll();
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    checkOutput("ovr_cleared", overrun, 0);

    // Tick coincident with done is dropped as well.
    startTick(randCur());
    waitDone(cyc);
    tick = 1'b1;
    i_in = randCur();
    @(posedge clk); #1;
    tick = 1'b0;
    nd = 0;
    repeat (10) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checkOutput("coinc_no_sweep", nd, 0);
    checkOutput("coinc_overrun", overrun, 1);
    checkOutput("coinc_spike", spike, mspike);
    readAll();

    // Set wins over clear in the same cycle.
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    checkOutput("prio_pre_clear", overrun, 0);
    startTick(randCur());
    tick = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    clr_overrun = 1'b0;
    checkOutput("prio_set_wins", overrun, 1);
    waitDone(cyc);
    checkOutput("prio_spike", spike, mspike);
    readAll();
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;

    // Random currents over many sweeps.
    doReset();
    for (int s = 0; s < 25; s++) applyStimulus(randCur());

    // Maximum negative drive: v falls monotonically to the floor without wrapping.
    doReset();
    cur = {N_CH{16'h8000}};
    for (int k = 0; k < N_CH; k++) prev_v[k] = VREST;
    for (int s = 0; s < 50; s++) begin
      applyStimulus(cur);
      checkOutput("neg_no_spike", spike, 0);
      for (int k = 0; k < N_CH; k++) begin
        checkOutput($sformatf("neg_mono[%0d]", k),
                    (last_v[k] <= prev_v[k]) && (last_v[k] <= 0), 1);
        prev_v[k] = last_v[k];
      end
    end
    checkOutput("neg_floor", last_v[0], VMIN);

    // Reset in the middle of a sweep abandons it.
    doReset();
    cur = {N_CH{16'h7FFF}};
    startTick(cur);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    nd = 0;
    repeat (10) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_done", nd, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_spike", spike, 0);
    readAll();
    applyStimulus('0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
